// File: rtl/md_unit.sv
//-----------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide unit for the EX stage. Owns the architectural
//   HI/LO registers. A mult/multu/div/divu computes its full result at the
//   start edge and parks it in hi_t/lo_t. The unit then counts down and commits
//   the result to HI/LO on the last busy cycle. mthi/mtlo write HI/LO
//   directly when idle.
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-low reset; clears all state
//   mdOP   in   4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                  6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   A      in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   B      in  32  rt operand (divisor / multiplier)
//   HI     out 32  architectural HI register
//   LO     out 32  architectural LO register
//   busy   out  1  multiply/divide in flight
//
// Revision: 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdOP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);

  // Counter must hold the longer of the two latencies, and never less than 4 bits.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_BITS < 4) ? 4 : CNT_BITS;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  // IDLE/RUN are fully encoded by the down-counter being zero or not.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Architectural and pending state
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      hi_t, lo_t;
  logic             dz_t;        // pending result came from a divide by zero
  logic [CNT_W-1:0] cnt;

  // Next-state values
  logic [31:0]      hi_q_d, lo_q_d;
  logic [31:0]      hi_t_d, lo_t_d;
  logic             dz_t_d;
  logic [CNT_W-1:0] cnt_d;

  state_e state;
  md_op_e op;

  assign state = (cnt != CNT_ZERO) ? S_RUN : S_IDLE;
  assign op    = md_op_e'(mdOP);

  //---------------------------------------------------------------------------
  // Multiplier: one 33x33 signed multiplier serves both flavours. Unsigned
  // operands get a zero extension bit, signed ones a sign extension bit.
  //---------------------------------------------------------------------------
  logic               mul_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] product;

  assign mul_signed = (op == OP_MULT);
  assign mul_a      = $signed({mul_signed & A[31], A});
  assign mul_b      = $signed({mul_signed & B[31], B});
  assign product    = mul_a * mul_b;

  //---------------------------------------------------------------------------
  // Divider: signed divide is done on magnitudes and then the signs are fixed
  // up. The quotient is negated when the operand signs differ, and the
  // remainder takes the dividend's sign. This makes 0x80000000 / -1 fall out
  // naturally: the magnitude 0x80000000 negates back onto itself.
  //---------------------------------------------------------------------------
  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] uquot, urem;
  logic [31:0] quot, rem;
  logic        div_by_zero;

  assign div_signed  = (op == OP_DIV);
  assign a_neg       = div_signed & A[31];
  assign b_neg       = div_signed & B[31];
  assign a_mag       = a_neg ? (32'd0 - A) : A;
  assign b_mag       = b_neg ? (32'd0 - B) : B;
  assign div_by_zero = (B == 32'd0);
  // Keep the divider well defined on B=0; that result is never committed.
  assign b_safe      = div_by_zero ? 32'd1 : b_mag;
  assign uquot       = a_mag / b_safe;
  assign urem        = a_mag % b_safe;
  assign quot        = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
  assign rem         = a_neg ? (32'd0 - urem) : urem;

  //---------------------------------------------------------------------------
  // Next-state logic
  //---------------------------------------------------------------------------
  always_comb begin
    hi_q_d = hi_q;
    lo_q_d = lo_q;
    hi_t_d = hi_t;
    lo_t_d = lo_t;
    dz_t_d = dz_t;
    cnt_d  = cnt;

    case (state)
      S_IDLE: begin
        case (op)
          OP_MULT, OP_MULTU: begin
            hi_t_d = product[63:32];
            lo_t_d = product[31:0];
            dz_t_d = 1'b0;
            cnt_d  = MULT_LOAD;
          end
          OP_DIV, OP_DIVU: begin
            hi_t_d = rem;
            lo_t_d = quot;
            dz_t_d = div_by_zero;
            cnt_d  = DIV_LOAD;
          end
          OP_MTHI: hi_q_d = A;
          OP_MTLO: lo_q_d = A;
          default: ;  // none, mfhi, mflo and 9-15 change nothing
        endcase
      end
      S_RUN: begin
        // Every opcode is ignored while running. Only the countdown moves.
        cnt_d = cnt - CNT_ONE;
        if ((cnt == CNT_ONE) && !dz_t) begin
          hi_q_d = hi_t;
          lo_q_d = lo_t;
        end
      end
      default: ;
    endcase
  end

  //---------------------------------------------------------------------------
  // State registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      hi_t <= 32'd0;
      lo_t <= 32'd0;
      dz_t <= 1'b0;
      cnt  <= CNT_ZERO;
    end else begin
      hi_q <= hi_q_d;
      lo_q <= lo_q_d;
      hi_t <= hi_t_d;
      lo_t <= lo_t_d;
      dz_t <= dz_t_d;
      cnt  <= cnt_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = (cnt != CNT_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
//-----------------------------------------------------------------------------
// tb_md_unit
//   Self-checking bench for md_unit. Directed scenarios followed by random
//   operation streams, all compared against a cycle-indexed reference model
//   built from 64-bit arithmetic.
//
// Revision: 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  mdOP;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        busy;

  int errors = 0;
  int checks = 0;

  md_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdOP (mdOP),
    .A    (A),
    .B    (B),
    .HI   (HI),
    .LO   (LO),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edge index plus the edge at which the pending op completes.
  int          edge_n   = 0;
  int          done_e   = 0;
  logic        pend     = 1'b0;
  logic        pend_dz  = 1'b0;
  logic [31:0] pend_hi  = '0;
  logic [31:0] pend_lo  = '0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_hi    = '0;
    m_lo    = '0;
    pend    = 1'b0;
    pend_dz = 1'b0;
    done_e  = edge_n;
  endtask

  // Apply one rising edge to the model, using the opcode sampled at that edge.
  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up, ua, ub;
    logic        idle;
    idle = (edge_n > done_e);
    if (pend && edge_n == done_e) begin
      if (!pend_dz) begin
        m_hi = pend_hi;
        m_lo = pend_lo;
      end
      pend = 1'b0;
    end
    if (idle) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
        4'd1: begin
          sp = sa * sb;
          {pend_hi, pend_lo} = sp;
          pend_dz = 1'b0; pend = 1'b1; done_e = edge_n + MULT_CYCLES;
        end
        4'd2: begin
          up = ua * ub;
          {pend_hi, pend_lo} = up;
          pend_dz = 1'b0; pend = 1'b1; done_e = edge_n + MULT_CYCLES;
        end
        4'd3: begin
          pend_dz = (b == 0);
          if (b != 0) begin
            sp = sa / sb;  pend_lo = sp[31:0];
            sp = sa % sb;  pend_hi = sp[31:0];
          end
          pend = 1'b1; done_e = edge_n + DIV_CYCLES;
        end
        4'd4: begin
          pend_dz = (b == 0);
          if (b != 0) begin
            up = ua / ub;  pend_lo = up[31:0];
            up = ua % ub;  pend_hi = up[31:0];
          end
          pend = 1'b1; done_e = edge_n + DIV_CYCLES;
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Drive one op for one cycle, then compare all outputs with the model.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdOP = op;
    A    = a;
    B    = b;
    @(posedge clk);
    edge_n++;
    model_edge(op, a, b);
    #1;
    check("busy", {31'd0, busy}, {31'd0, (edge_n < done_e)});
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(4'd0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 7))
      0:       w = 32'd0;
      1:       w = 32'hFFFF_FFFF;
      2:       w = 32'h8000_0000;
      3:       w = 32'd1;
      4:       w = $urandom_range(0, 15);
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    mdOP  = 4'd0;
    A     = '0;
    B     = '0;

    // Held reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset dropped mid-multiply discards the pending result
    step(4'd1, 32'd7, 32'd9);
    step(4'd0, 0, 0);
    step(4'd0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_HI", HI, 32'd0);
    check("async_LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_steps(MULT_CYCLES + 2);
    check("nocommit_LO", LO, 32'd0);

    // mult -2 * 3
    step(4'd1, 32'hFFFF_FFFE, 32'd3);
    idle_steps(MULT_CYCLES);
    check("mult_HI", HI, 32'hFFFF_FFFF);
    check("mult_LO", LO, 32'hFFFF_FFFA);

    // multu max * max
    step(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_steps(MULT_CYCLES);
    check("multu_HI", HI, 32'hFFFF_FFFE);
    check("multu_LO", LO, 32'h0000_0001);

    // div / divu -7 by 2
    step(4'd3, 32'hFFFF_FFF9, 32'd2);
    idle_steps(DIV_CYCLES);
    check("div_HI", HI, 32'hFFFF_FFFF);
    check("div_LO", LO, 32'hFFFF_FFFD);
    step(4'd4, 32'hFFFF_FFF9, 32'd2);
    idle_steps(DIV_CYCLES);
    check("divu_HI", HI, 32'd1);
    check("divu_LO", LO, 32'h7FFF_FFFC);

    // Overflow case 0x80000000 / -1
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_steps(DIV_CYCLES);
    check("ovf_HI", HI, 32'd0);
    check("ovf_LO", LO, 32'h8000_0000);

    // Divide by zero leaves HI/LO alone
    step(4'd5, 32'h11, 0);
    step(4'd6, 32'h22, 0);
    step(4'd3, 32'd1234, 32'd0);
    idle_steps(DIV_CYCLES);
    check("dz_HI", HI, 32'h11);
    check("dz_LO", LO, 32'h22);

    // Overlap: ops while busy ignored, including at the edge busy falls
    step(4'd1, 32'd5, 32'd6);
    step(4'd6, 32'h99, 0);
    step(4'd4, 32'd100, 32'd7);
    step(4'd0, 0, 0);
    step(4'd0, 0, 0);
    step(4'd6, 32'h99, 0);
    check("ovl_HI", HI, 32'd0);
    check("ovl_LO", LO, 32'd30);
    check("ovl_busy", {31'd0, busy}, 32'd0);
    step(4'd6, 32'h99, 0);
    check("ovl_mtlo", LO, 32'h99);

    // Random streams
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom_range(0, 15)), rand_word(), rand_word());
    end
    idle_steps(DIV_CYCLES + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the pipelined MIPS core. It takes the decoded `mdOP` and the two EX-stage register operands, runs multi-cycle multiply and divide, and owns the architectural HI/LO registers. It returns HI/LO to the EX result mux for `mfhi`/`mflo`. The unit raises `busy` while an operation is in flight, and EX combines it into the pipeline stall.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`  in  1  rising-edge clock; the unit's only clock.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `mdOP`  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 are treated as none.
- `A`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- `B`  in  32  rt operand (divisor / multiplier).
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.
- `busy`  out  1  operation in flight.

## Operation
- State:
  - `hi_q`, `lo_q`: architectural registers.
  - `hi_t`, `lo_t`: pending results.
  - `cnt`: down-counter, 4 bits minimum, wide enough for `DIV_CYCLES`.
- States: IDLE (`cnt`=0) and RUN (`cnt`≠0). `busy` = (`cnt`≠0), driven directly from the register.
- IDLE, mdOP 1–4 sampled at a rising edge:
  - Compute the full result from A/B at that edge and latch it into `hi_t`/`lo_t`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
- Arithmetic:
  - mult: 64-bit `$signed(A)*$signed(B)`; HI = [63:32], LO = [31:0].
  - multu: unsigned 64-bit product, same split.
  - div: LO = signed quotient, truncated toward zero; HI = remainder carrying the dividend's sign (0x80000000 / -1 gives LO=0x80000000, HI=0).
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0) for div/divu: still takes `DIV_CYCLES`, but `hi_q`/`lo_q` stay unchanged at completion.
- RUN: `cnt` decrements each edge. At the edge where `cnt`=1, commit `hi_t`/`lo_t` to `hi_q`/`lo_q` (unless divide by zero) and `cnt` becomes 0.
- mthi/mtlo, sampled in IDLE: `hi_q`/`lo_q` ← A at that edge; no busy.
- mfhi/mflo and none: no state change. HI/LO outputs are always `hi_q`/`lo_q`.
- Any mdOP 1–6 sampled while in RUN is ignored, with no state change. EX is responsible for stalling these.
- Reset low, including mid-operation: `hi_q`, `lo_q`, `hi_t`, `lo_t`, `cnt` → 0 asynchronously; the pending result is discarded.

## Timing
- Reset values: HI=0, LO=0, busy=0.
- Multiply, start sampled at edge k:
  - busy=1 from after edge k through edge k+`MULT_CYCLES`.
  - HI/LO carry the new result and busy=0 after edge k+`MULT_CYCLES`; busy is high for exactly `MULT_CYCLES` cycles.
- Divide: same as multiply, with `DIV_CYCLES`.
- Back-to-back: a new start sampled at the same edge where busy falls (i.e. the sampling edge sees `cnt`=1) is ignored. The earliest accepted start is the first edge at which `cnt`=0.
- mthi/mtlo: HI/LO show A one cycle after the sampling edge.
- mfhi/mflo: purely combinational from the registers, zero latency.
- busy never asserts in the same cycle as the start; EX covers that cycle with its own `start` term.

## Test plan
- Reset: hold `reset`=0 → HI=0, LO=0, busy=0. Start a mult, drop reset after 2 cycles → busy=0 and HI/LO=0 immediately; no commit afterwards.
- mult, A=0xFFFFFFFE (-2), B=3:
  - busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO unchanged during the 5 busy cycles.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Same operands with divu → LO=0x7FFFFFFC, HI=1.
- Divide by zero: mthi 0x11, mtlo 0x22, then div with B=0 → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Overlap: issue a mult (A=5, B=6), then mtlo 0x99 and a divu while busy.
  - Both are ignored; final LO=30, HI=0.
  - An mtlo 0x99 sampled at the first edge with `cnt`=0 gives LO=0x99 one cycle later.
